// File: rtl/yapp_router_pkg.sv
// YAPP router shared types and constants.
// Register map, reset values and FSM states.
package yapp_router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    PARITY
  } state_e;

  localparam logic [15:0] REG_MAXPKT = 16'h1000;
  localparam logic [15:0] REG_EN     = 16'h1001;
  localparam logic [15:0] REG_CHMASK = 16'h1002;
  localparam logic [15:0] REG_PARCNT = 16'h1003;
  localparam logic [15:0] REG_DRPCNT = 16'h1004;

  localparam logic [5:0] MAXPKT_RST = 6'd63;
  localparam logic       EN_RST     = 1'b1;
  localparam logic [3:0] CHMASK_RST = 4'hF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/yapp_chan_fifo.sv
// Per-channel show-ahead FIFO.
// A push into a full FIFO succeeds only when a pop frees the slot.
module yapp_chan_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [CW-1:0]     r_cnt;
  logic              w_push;
  logic              w_pop;

  assign full   = (r_cnt == CW'(FIFO_DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign dout   = r_mem[r_rd];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  // storage array, no reset needed
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/yapp_router_np.sv
// Parametrised cut-through YAPP router.
// Input FSM, filtering, parity check, HBUS register bank.
module yapp_router_np
  import yapp_router_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int HADDR_W    = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_data_vld,
  output logic                     in_suspend,
  output logic [NUM_CH*DATA_W-1:0] data,
  output logic [NUM_CH-1:0]        data_vld,
  input  logic [NUM_CH-1:0]        suspend,
  input  logic [HADDR_W-1:0]       haddr,
  input  logic [7:0]               hdata_w,
  output logic [7:0]               hdata_r,
  input  logic                     hen,
  input  logic                     hwr_rd,
  output logic                     error
);

  localparam int LEN_W = DATA_W - 2;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  state_e             r_state;
  state_e             w_next;
  logic [1:0]         r_addr;
  logic [LEN_W-1:0]   r_len_cnt;
  logic [DATA_W-1:0]  r_par;
  logic               r_drop;
  logic               r_error;
  logic [5:0]         r_maxpkt;
  logic               r_en;
  logic [NUM_CH-1:0]  r_chmask;
  logic [7:0]         r_par_cnt;
  logic [7:0]         r_drop_cnt;
  logic [7:0]         r_hdata;
  logic [7:0]         w_rdata;

  logic [1:0]         w_hdr_addr;
  logic [LEN_W-1:0]   w_hdr_len;
  logic               w_hdr_drop;
  logic [1:0]         w_cur_addr;
  logic               w_cur_drop;
  logic               w_acc;
  logic               w_par_err;
  logic               w_wr;
  logic [3:0]         w_mask4;
  logic [3:0]         w_full4;
  logic [NUM_CH-1:0]  w_full;
  logic [NUM_CH-1:0]  w_empty;
  logic [NUM_CH-1:0]  w_push;
  logic [DATA_W-1:0]  w_dout [NUM_CH];
  logic [CW-1:0]      w_cnt  [NUM_CH];

  assign w_hdr_addr = in_data[1:0];
  assign w_hdr_len  = in_data[DATA_W-1:2];
  assign w_mask4    = 4'(r_chmask);
  assign w_full4    = 4'(w_full);
  assign w_hdr_drop = !({1'b0, w_hdr_addr} < 3'(NUM_CH))
                   || !w_mask4[w_hdr_addr]
                   || (w_hdr_len > LEN_W'(r_maxpkt))
                   || !r_en;
  assign w_cur_addr = (r_state == IDLE) ? w_hdr_addr : r_addr;
  assign w_cur_drop = (r_state == IDLE) ? w_hdr_drop : r_drop;
  assign in_suspend = !w_cur_drop && w_full4[w_cur_addr];
  assign w_acc      = in_data_vld && !in_suspend;
  assign w_par_err  = w_acc && (r_state == PARITY)
                   && (r_par != in_data);
  assign w_wr       = hen && hwr_rd;
  assign error      = r_error;
  assign hdata_r    = r_hdata;

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // packet framing: header, len payload bytes, parity
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (w_acc)
          w_next = (w_hdr_len == '0) ? PARITY : PAYLOAD;
      PAYLOAD:
        if (w_acc && r_len_cnt == '0) w_next = PARITY;
      PARITY:
        if (w_acc) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // per-packet context: route, drop flag, running parity
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr    <= '0;
      r_len_cnt <= '0;
      r_par     <= '0;
      r_drop    <= 1'b0;
    end else if (w_acc) begin
      if (r_state == IDLE) begin
        r_addr    <= w_hdr_addr;
        r_drop    <= w_hdr_drop;
        r_par     <= in_data;
        r_len_cnt <= w_hdr_len - 1'b1;
      end else if (r_state == PAYLOAD) begin
        r_par     <= r_par ^ in_data;
        r_len_cnt <= r_len_cnt - 1'b1;
      end
    end
  end

  // error pulse the cycle after a drop or parity fault
  always_ff @(posedge clock) begin
    if (reset) r_error <= 1'b0;
    else       r_error <= (w_acc && r_state == IDLE && w_hdr_drop)
                       || w_par_err;
  end

  // config registers and saturating counters
  always_ff @(posedge clock) begin
    if (reset) begin
      r_maxpkt   <= MAXPKT_RST;
      r_en       <= EN_RST;
      r_chmask   <= CHMASK_RST[NUM_CH-1:0];
      r_par_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_wr && haddr == HADDR_W'(REG_MAXPKT))
        r_maxpkt <= hdata_w[5:0];
      if (w_wr && haddr == HADDR_W'(REG_EN))
        r_en <= hdata_w[0];
      if (w_wr && haddr == HADDR_W'(REG_CHMASK))
        r_chmask <= hdata_w[NUM_CH-1:0];
      if (w_wr && haddr == HADDR_W'(REG_PARCNT))
        r_par_cnt <= '0;
      else if (w_par_err)
        r_par_cnt <= sat_inc(r_par_cnt);
      if (w_wr && haddr == HADDR_W'(REG_DRPCNT))
        r_drop_cnt <= '0;
      else if (w_acc && r_state == IDLE && w_hdr_drop)
        r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  // register read mux
  always_comb begin
    w_rdata = 8'h00;
    unique case (1'b1)
      haddr == HADDR_W'(REG_MAXPKT): w_rdata = 8'(r_maxpkt);
      haddr == HADDR_W'(REG_EN):     w_rdata = 8'(r_en);
      haddr == HADDR_W'(REG_CHMASK): w_rdata = 8'(r_chmask);
      haddr == HADDR_W'(REG_PARCNT): w_rdata = r_par_cnt;
      haddr == HADDR_W'(REG_DRPCNT): w_rdata = r_drop_cnt;
      default:                       w_rdata = 8'h00;
    endcase
  end

  // read data held until the next read strobe
  always_ff @(posedge clock) begin
    if (reset)             r_hdata <= '0;
    else if (hen && !hwr_rd) r_hdata <= w_rdata;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_push[i]   = w_acc && !w_cur_drop
                      && (w_cur_addr == 2'(i));
    assign data_vld[i] = (w_cnt[i] != '0) && !suspend[i];
    assign data[i*DATA_W +: DATA_W] =
      w_empty[i] ? '0 : w_dout[i];

    yapp_chan_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (w_push[i]),
      .din   (in_data),
      .pop   (data_vld[i]),
      .dout  (w_dout[i]),
      .full  (w_full[i]),
      .empty (w_empty[i]),
      .count (w_cnt[i])
    );
  end

endmodule

// File: tb/tb_yapp_router_np.sv
// Directed bench for yapp_router_np.
// Scoreboard queues per channel, checked by a monitor.
module tb_yapp_router_np;

  localparam int DW = 8;
  localparam int NC = 3;
  localparam int FD = 16;
  localparam int HW = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic [DW-1:0]   in_data;
  logic            in_data_vld;
  logic            in_suspend;
  logic [NC*DW-1:0] data;
  logic [NC-1:0]   data_vld;
  logic [NC-1:0]   suspend;
  logic [HW-1:0]   haddr;
  logic [7:0]      hdata_w;
  logic [7:0]      hdata_r;
  logic            hen;
  logic            hwr_rd;
  logic            error;

  logic [7:0] sb [NC][$];
  int n_tests = 0;
  int n_fail  = 0;
  int out_cnt [NC];
  int err_cnt = 0;
  int stall_cnt = 0;
  int first_stall = -1;
  int acc_cnt = 0;
  bit auto_rel = 1'b0;

  always #5 clock = ~clock;

  yapp_router_np #(
    .DATA_W(DW), .NUM_CH(NC), .FIFO_DEPTH(FD), .HADDR_W(HW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_data_vld (in_data_vld),
    .in_suspend  (in_suspend),
    .data        (data),
    .data_vld    (data_vld),
    .suspend     (suspend),
    .haddr       (haddr),
    .hdata_w     (hdata_w),
    .hdata_r     (hdata_r),
    .hen         (hen),
    .hwr_rd      (hwr_rd),
    .error       (error)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  // output monitor pops the scoreboard
  always @(negedge clock) begin
    if (error === 1'b1) err_cnt++;
    if (reset === 1'b0) begin
      for (int i = 0; i < NC; i++) begin
        if (data_vld[i] === 1'b1) begin
          if (sb[i].size() == 0) begin
            chk("ch_spurious_vld", 32'(data_vld[i]), 32'd0);
          end else begin
            chk("ch_data", 32'(data[i*DW +: DW]),
                32'(sb[i].pop_front()));
            out_cnt[i]++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int st;
    bit rel;
    st = 0;
    in_data = b;
    in_data_vld = 1'b1;
    forever begin
      @(negedge clock);
      if (!in_suspend) break;
      if (first_stall < 0) first_stall = acc_cnt;
      st++;
      stall_cnt++;
      rel = auto_rel && (st == 5);
      if (st > 300) begin
        chk("send_timeout", 32'(in_suspend), 32'd0);
        break;
      end
      tick();
      if (rel) suspend = '0;
    end
    tick();
    acc_cnt++;
  endtask

  task automatic send_pkt(input logic [1:0] a, input int len,
                          input logic [7:0] mul, input bit bad,
                          input bit fwd);
    logic [7:0] hdr;
    logic [7:0] p;
    logic [7:0] b;
    hdr = {6'(len), a};
    p = hdr;
    if (fwd) sb[a].push_back(hdr);
    send_byte(hdr);
    for (int k = 0; k < len; k++) begin
      b = 8'(int'(mul) * (k + 1));
      p = p ^ b;
      if (fwd) sb[a].push_back(b);
      send_byte(b);
    end
    b = bad ? ~p : p;
    if (fwd) sb[a].push_back(b);
    send_byte(b);
    in_data_vld = 1'b0;
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0
           && c < 500) begin
      tick();
      c++;
    end
    chk(tag, 32'(sb[0].size() + sb[1].size() + sb[2].size()),
        32'd0);
    repeat (3) tick();
  endtask

  task automatic hb_write(input logic [15:0] a, input logic [7:0] d);
    haddr = a; hdata_w = d; hen = 1'b1; hwr_rd = 1'b1;
    tick();
    hen = 1'b0; hwr_rd = 1'b0;
  endtask

  task automatic hb_read(input logic [15:0] a, output logic [7:0] d);
    haddr = a; hen = 1'b1; hwr_rd = 1'b0;
    tick();
    hen = 1'b0;
    d = hdata_r;
  endtask

  initial begin
    logic [7:0] rd;
    int e0;
    int o0, o1, o2;
    int s0;

    reset = 1'b1; in_data = '0; in_data_vld = 1'b0;
    suspend = '0; haddr = '0; hdata_w = '0;
    hen = 1'b0; hwr_rd = 1'b0;
    for (int i = 0; i < NC; i++) out_cnt[i] = 0;
    repeat (3) tick();
    chk("rst_in_suspend", 32'(in_suspend), 32'd0);
    chk("rst_data_vld", 32'(data_vld), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_hdata_r", 32'(hdata_r), 32'd0);
    reset = 1'b0;
    tick();

    // 1: good packet to ch1
    e0 = err_cnt; o0 = out_cnt[0]; o1 = out_cnt[1]; o2 = out_cnt[2];
    send_pkt(2'd1, 3, 8'h11, 1'b0, 1'b1);
    drain("t1_drain");
    chk("t1_ch1_bytes", 32'(out_cnt[1] - o1), 32'd5);
    chk("t1_ch0_idle", 32'(out_cnt[0] - o0), 32'd0);
    chk("t1_ch2_idle", 32'(out_cnt[2] - o2), 32'd0);
    chk("t1_no_error", 32'(err_cnt - e0), 32'd0);

    // 2: bad parity still forwarded
    e0 = err_cnt; o1 = out_cnt[1];
    send_pkt(2'd1, 3, 8'h11, 1'b1, 1'b1);
    drain("t2_drain");
    chk("t2_ch1_bytes", 32'(out_cnt[1] - o1), 32'd5);
    chk("t2_err_pulse", 32'(err_cnt - e0), 32'd1);
    hb_read(16'h1003, rd);
    chk("t2_par_cnt", 32'(rd), 32'h01);

    // 3: bad address, then oversize packet
    e0 = err_cnt; s0 = stall_cnt;
    o0 = out_cnt[0]; o1 = out_cnt[1]; o2 = out_cnt[2];
    send_pkt(2'd3, 2, 8'h05, 1'b0, 1'b0);
    hb_write(16'h1000, 8'd4);
    send_pkt(2'd0, 5, 8'h07, 1'b0, 1'b0);
    repeat (4) tick();
    chk("t3_no_stall", 32'(stall_cnt - s0), 32'd0);
    chk("t3_err_pulses", 32'(err_cnt - e0), 32'd2);
    chk("t3_no_out",
        32'((out_cnt[0] - o0) + (out_cnt[1] - o1) + (out_cnt[2] - o2)),
        32'd0);
    hb_read(16'h1004, rd);
    chk("t3_drop_cnt", 32'(rd), 32'h02);
    hb_write(16'h1000, 8'd63);

    // 4: backpressure on ch0
    o0 = out_cnt[0];
    suspend = 3'b001;
    auto_rel = 1'b1;
    first_stall = -1;
    acc_cnt = 0;
    send_pkt(2'd0, 18, 8'h0B, 1'b0, 1'b1);
    auto_rel = 1'b0;
    drain("t4_drain");
    chk("t4_first_stall", 32'(first_stall), 32'd16);
    chk("t4_ch0_bytes", 32'(out_cnt[0] - o0), 32'd20);

    // 5: global enable
    e0 = err_cnt; o2 = out_cnt[2];
    hb_write(16'h1001, 8'h00);
    send_pkt(2'd2, 2, 8'h21, 1'b0, 1'b0);
    repeat (3) tick();
    chk("t5_disabled", 32'(out_cnt[2] - o2), 32'd0);
    hb_write(16'h1001, 8'h01);
    send_pkt(2'd2, 2, 8'h21, 1'b0, 1'b1);
    drain("t5_drain");
    chk("t5_ch2_bytes", 32'(out_cnt[2] - o2), 32'd4);
    chk("t5_err_pulse", 32'(err_cnt - e0), 32'd1);
    hb_read(16'h1001, rd);
    chk("t5_en_rd", 32'(rd), 32'h01);
    hb_read(16'h10FF, rd);
    chk("t5_unmapped", 32'(rd), 32'h00);
    hb_read(16'h1002, rd);
    chk("t5_chmask", 32'(rd), 32'h07);

    // 6: reset mid-payload
    hb_write(16'h1000, 8'd10);
    hb_read(16'h1000, rd);
    chk("t6_maxpkt_wr", 32'(rd), 32'd10);
    o1 = out_cnt[1];
    suspend = 3'b010;
    send_byte(8'h15);
    send_byte(8'h01);
    send_byte(8'h02);
    in_data_vld = 1'b0;
    reset = 1'b1;
    tick();
    chk("t6_in_suspend", 32'(in_suspend), 32'd0);
    chk("t6_data_vld", 32'(data_vld), 32'd0);
    chk("t6_data", 32'(data), 32'd0);
    chk("t6_error", 32'(error), 32'd0);
    chk("t6_hdata_r", 32'(hdata_r), 32'd0);
    reset = 1'b0;
    suspend = '0;
    repeat (5) tick();
    chk("t6_flushed", 32'(out_cnt[1] - o1), 32'd0);
    hb_read(16'h1000, rd);
    chk("t6_maxpkt_rst", 32'(rd), 32'd63);
    hb_read(16'h1004, rd);
    chk("t6_drop_rst", 32'(rd), 32'd0);
    hb_read(16'h1003, rd);
    chk("t6_par_rst", 32'(rd), 32'd0);
    send_pkt(2'd1, 3, 8'h11, 1'b0, 1'b1);
    drain("t6_drain");
    chk("t6_ch1_bytes", 32'(out_cnt[1] - o1), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
